// File: rtl/axi_read_arbiter.sv
// Arbitrates the single AXI read channel between the I-cache and D-cache refill FSMs.
// The arbiter grants one requester per burst and holds the grant until that burst's last beat.
// Read beats are routed only to the granted cache, and the beat count is checked on each last beat.
// Default build: fixed priority, data wins over instruction.
// Define ARB_ROUND_ROBIN_EN to switch to round-robin: on a tie, the side not granted last wins.
module axi_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_instr_start_read,
    input  logic [ADDR_WIDTH-1:0] i_instr_addr,
    input  logic                  i_data_start_read,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    output logic                  o_start_read_axi,
    output logic [ADDR_WIDTH-1:0] o_read_addr_axi,
    input  logic                  i_r_valid_axi,
    input  logic                  i_read_last_axi,
    input  logic [DATA_WIDTH-1:0] i_r_data_axi,
    output logic                  o_instr_r_valid,
    output logic                  o_instr_r_last,
    output logic                  o_data_r_valid,
    output logic                  o_data_r_last,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_busy,
    output logic                  o_len_err
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             any_req;
    logic             win_d;
    logic             beat_in;
    logic             last_beat;

`ifdef ARB_ROUND_ROBIN_EN
    logic             last_d;
`endif

    // Winner selection among the currently raised requests
    always_comb begin
        any_req = i_instr_start_read | i_data_start_read;
`ifdef ARB_ROUND_ROBIN_EN
        win_d   = i_data_start_read & (~i_instr_start_read | ~last_d);
`else
        win_d   = i_data_start_read;
`endif
    end

    // Next-state logic and combinational beat routing
    always_comb begin
        state_nxt       = state;
        beat_in         = 1'b0;
        last_beat       = 1'b0;
        o_instr_r_valid = 1'b0;
        o_instr_r_last  = 1'b0;
        o_data_r_valid  = 1'b0;
        o_data_r_last   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = win_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: begin
                beat_in         = i_r_valid_axi;
                last_beat       = i_r_valid_axi & i_read_last_axi;
                o_instr_r_valid = i_r_valid_axi;
                o_instr_r_last  = i_r_valid_axi & i_read_last_axi;
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            GRANT_D: begin
                beat_in        = i_r_valid_axi;
                last_beat      = i_r_valid_axi & i_read_last_axi;
                o_data_r_valid = i_r_valid_axi;
                o_data_r_last  = i_r_valid_axi & i_read_last_axi;
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant-time start pulse, address latch, beat counter and sticky length error
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            o_start_read_axi <= 1'b0;
            o_read_addr_axi  <= '0;
            beat_cnt         <= '0;
            o_len_err        <= 1'b0;
        end else begin
            o_start_read_axi <= 1'b0;
            if ((state == IDLE) && any_req) begin
                o_start_read_axi <= 1'b1;
                o_read_addr_axi  <= win_d ? i_data_addr : i_instr_addr;
                beat_cnt         <= '0;
            end else if (beat_in) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (last_beat && ((beat_cnt + CNT_W'(1)) != CNT_W'(BURST_LEN))) begin
                o_len_err <= 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember which side was granted last; reset means data was granted last
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            last_d <= 1'b1;
        end else if ((state == IDLE) && any_req) begin
            last_d <= win_d;
        end
    end
`endif

    assign o_r_data = i_r_data_axi;
    assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter. Expected grants are queued as requests are raised.
// Each start pulse pops one entry, and the bench then plays a read burst for it.
module tb_axi_read_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 16;

    logic          clk;
    logic          arstn;
    logic          i_instr_start_read;
    logic [AW-1:0] i_instr_addr;
    logic          i_data_start_read;
    logic [AW-1:0] i_data_addr;
    logic          o_start_read_axi;
    logic [AW-1:0] o_read_addr_axi;
    logic          i_r_valid_axi;
    logic          i_read_last_axi;
    logic [DW-1:0] i_r_data_axi;
    logic          o_instr_r_valid;
    logic          o_instr_r_last;
    logic          o_data_r_valid;
    logic          o_data_r_last;
    logic [DW-1:0] o_r_data;
    logic          o_busy;
    logic          o_len_err;

    typedef struct {
        logic          d;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk                (clk),
        .arstn              (arstn),
        .i_instr_start_read (i_instr_start_read),
        .i_instr_addr       (i_instr_addr),
        .i_data_start_read  (i_data_start_read),
        .i_data_addr        (i_data_addr),
        .o_start_read_axi   (o_start_read_axi),
        .o_read_addr_axi    (o_read_addr_axi),
        .i_r_valid_axi      (i_r_valid_axi),
        .i_read_last_axi    (i_read_last_axi),
        .i_r_data_axi       (i_r_data_axi),
        .o_instr_r_valid    (o_instr_r_valid),
        .o_instr_r_last     (o_instr_r_last),
        .o_data_r_valid     (o_data_r_valid),
        .o_data_r_last      (o_data_r_last),
        .o_r_data           (o_r_data),
        .o_busy             (o_busy),
        .o_len_err          (o_len_err)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a start pulse; returns the number of cycles waited
    task automatic wait_start(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1;
            if (o_start_read_axi) begin
                ok  = 1'b1;
                cyc = c;
                break;
            end
        end
        if (!ok) check_eq("start_timeout", 64'd0, 64'd1);
    endtask

    // Serve one expected grant with nbeats beats; optionally raise a data request mid-burst
    task automatic do_burst(input int nbeats, input int exp_lat, input int inj_beat,
                            input logic [AW-1:0] inj_addr);
        bit   ok;
        int   cyc;
        exp_t e;
        logic [DW-1:0] dat;
        wait_start(ok, cyc);
        if (!ok) return;
        if (exp_lat >= 0) check_eq("start_latency", 64'(cyc), 64'(exp_lat));
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("grant_addr", o_read_addr_axi, e.addr);
        for (int i = 0; i < nbeats; i++) begin
            dat             = DW'($urandom);
            i_r_valid_axi   = 1'b1;
            i_read_last_axi = (i == nbeats - 1);
            i_r_data_axi    = dat;
            if (i == 1) begin
                if (e.d) i_data_addr = 64'hDEAD_BEEF_0000_0000;
                else     i_instr_addr = 64'hBAD0_BAD0_0000_0000;
            end
            if (i == inj_beat) begin
                i_data_start_read = 1'b1;
                i_data_addr       = inj_addr;
                sb.push_back('{1'b1, inj_addr});
            end
            #1;
            check_eq("route_valid", {62'd0, o_instr_r_valid, o_data_r_valid},
                     e.d ? 64'd1 : 64'd2);
            check_eq("route_last", {62'd0, o_instr_r_last, o_data_r_last},
                     (i == nbeats - 1) ? (e.d ? 64'd1 : 64'd2) : 64'd0);
            check_eq("r_data", 64'(o_r_data), 64'(dat));
            check_eq("addr_hold", o_read_addr_axi, e.addr);
            check_eq("start_pulse", 64'(o_start_read_axi), (i == 0) ? 64'd1 : 64'd0);
            check_eq("busy", 64'(o_busy), 64'd1);
            @(negedge clk);
            #1;
        end
        i_r_valid_axi   = 1'b0;
        i_read_last_axi = 1'b0;
        if (e.d) i_data_start_read = 1'b0;
        else     i_instr_start_read = 1'b0;
        if (nbeats != int'(BL)) exp_err = 1'b1;
        check_eq("idle_after_last", {62'd0, o_busy, o_start_read_axi}, 64'd0);
        check_eq("len_err", 64'(o_len_err), 64'(exp_err));
    endtask

    initial begin
        bit   ok;
        int   cyc;
        exp_t e;

        arstn              = 1'b0;
        i_instr_start_read = 1'b0;
        i_instr_addr       = '0;
        i_data_start_read  = 1'b0;
        i_data_addr        = '0;
        i_r_valid_axi      = 1'b0;
        i_read_last_axi    = 1'b0;
        i_r_data_axi       = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_outs", {59'd0, o_start_read_axi, o_instr_r_valid, o_data_r_valid,
                 o_busy, o_len_err}, 64'd0);
        check_eq("rst_addr", o_read_addr_axi, 64'd0);
        @(negedge clk);
        arstn = 1'b1;

        // Tie: both requests raised in the same cycle
        @(negedge clk);
        i_instr_addr       = 64'h200;
        i_data_addr        = 64'h300;
        i_instr_start_read = 1'b1;
        i_data_start_read  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        sb.push_back('{1'b0, 64'h200});
        sb.push_back('{1'b1, 64'h300});
`else
        sb.push_back('{1'b1, 64'h300});
        sb.push_back('{1'b0, 64'h200});
`endif
        do_burst(16, 1, -1, '0);
        do_burst(16, 1, -1, '0);

        // Instruction request alone
        @(negedge clk);
        i_instr_addr       = 64'h100;
        i_instr_start_read = 1'b1;
        sb.push_back('{1'b0, 64'h100});
        do_burst(16, 1, -1, '0);

        // Data request arrives mid instruction burst; address is sampled at its grant
        @(negedge clk);
        i_instr_addr       = 64'h400;
        i_instr_start_read = 1'b1;
        sb.push_back('{1'b0, 64'h400});
        do_burst(16, 1, 3, 64'h500);
        do_burst(16, 1, -1, '0);

        // Short burst sets the sticky length error; a good burst leaves it set
        @(negedge clk);
        i_instr_addr       = 64'h600;
        i_instr_start_read = 1'b1;
        sb.push_back('{1'b0, 64'h600});
        do_burst(12, 1, -1, '0);
        @(negedge clk);
        i_data_addr       = 64'h700;
        i_data_start_read = 1'b1;
        sb.push_back('{1'b1, 64'h700});
        do_burst(16, 1, -1, '0);

        // Reset asserted at beat 5 of a data burst, instruction request pending
        @(negedge clk);
        i_data_addr       = 64'h800;
        i_data_start_read = 1'b1;
        sb.push_back('{1'b1, 64'h800});
        wait_start(ok, cyc);
        e = sb.pop_front();
        check_eq("rst_burst_addr", o_read_addr_axi, e.addr);
        for (int i = 0; i < 4; i++) begin
            i_r_valid_axi = 1'b1;
            @(negedge clk);
            #1;
        end
        i_instr_addr       = 64'h900;
        i_instr_start_read = 1'b1;
        #1;
        check_eq("beat5_routed", 64'(o_data_r_valid), 64'd1);
        arstn = 1'b0;
        #1;
        exp_err = 1'b0;
        check_eq("async_rst_outs", {59'd0, o_start_read_axi, o_instr_r_valid, o_data_r_valid,
                 o_busy, o_len_err}, 64'd0);
        check_eq("async_rst_addr", o_read_addr_axi, 64'd0);
        i_data_start_read = 1'b0;
        i_r_valid_axi     = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        sb.push_back('{1'b0, 64'h900});
        do_burst(16, 1, -1, '0);

        // Stray beats in IDLE are neither routed nor counted
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            i_r_valid_axi   = 1'b1;
            i_read_last_axi = (c == 2);
            #1;
            check_eq("stray_route", {60'd0, o_instr_r_valid, o_instr_r_last, o_data_r_valid,
                     o_data_r_last}, 64'd0);
            check_eq("stray_busy", 64'(o_busy), 64'd0);
            @(negedge clk);
        end
        i_r_valid_axi   = 1'b0;
        i_read_last_axi = 1'b0;
        #1;
        check_eq("stray_len_err", 64'(o_len_err), 64'd0);
        i_data_addr       = 64'hA00;
        i_data_start_read = 1'b1;
        sb.push_back('{1'b1, 64'hA00});
        do_burst(16, 1, -1, '0);

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
